// File: rtl/vx_bank_core_req_queue.sv
// vx_bank_core_req_queue: per-bank batch FIFO that serializes each multi-lane request to one lane per pop
module vx_bank_core_req_queue #(
  parameter int NUM_REQUESTS = 4,
  parameter int WORD_SIZE    = 4,
  parameter int ADDR_WIDTH   = 30,
  parameter int TAG_WIDTH    = 8,
  parameter int QUEUE_SIZE   = 4,
  localparam int TW = NUM_REQUESTS > 1 ? $clog2(NUM_REQUESTS) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQUESTS-1:0]               push_valid,
  input  logic [NUM_REQUESTS-1:0]               push_rw,
  input  logic [NUM_REQUESTS*WORD_SIZE-1:0]     push_byteen,
  input  logic [NUM_REQUESTS*ADDR_WIDTH-1:0]    push_addr,
  input  logic [NUM_REQUESTS*8*WORD_SIZE-1:0]   push_data,
  input  logic [TAG_WIDTH-1:0]                  push_tag,
  output logic                                  full,
  output logic                                  empty,
  input  logic                                  pop,
  output logic                                  out_valid,
  output logic [TW-1:0]                         out_tid,
  output logic                                  out_rw,
  output logic [WORD_SIZE-1:0]                  out_byteen,
  output logic [ADDR_WIDTH-1:0]                 out_addr,
  output logic [8*WORD_SIZE-1:0]                out_data,
  output logic [TAG_WIDTH-1:0]                  out_tag
);
  localparam int N  = NUM_REQUESTS;
  localparam int DW = 8 * WORD_SIZE;
  localparam int PW = $clog2(QUEUE_SIZE);
  localparam int SW = $clog2(QUEUE_SIZE + 1);
  logic [N-1:0]           mask_mem   [QUEUE_SIZE];
  logic [N-1:0]           rw_mem     [QUEUE_SIZE];
  logic [N*WORD_SIZE-1:0] byteen_mem [QUEUE_SIZE];
  logic [N*ADDR_WIDTH-1:0] addr_mem  [QUEUE_SIZE];
  logic [N*DW-1:0]        data_mem   [QUEUE_SIZE];
  logic [TAG_WIDTH-1:0]   tag_mem    [QUEUE_SIZE];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [SW-1:0] size, size_next;
  logic [N-1:0]  head_mask, lane_sel, rest, next_head;
  logic          accept, do_pop, retire;
  assign out_valid = !empty;
  assign accept    = |push_valid && !full;
  assign do_pop    = pop && out_valid;
  assign rest      = head_mask & ~lane_sel;
  assign retire    = do_pop && rest == '0;
  assign size_next = size + SW'(accept) - SW'(retire);
  assign next_head = size == SW'(1) ? (accept ? push_valid : '0) : mask_mem[rd_ptr + PW'(1)];
  always_comb begin
    out_tid    = '0;
    lane_sel   = '0;
    out_rw     = rw_mem[rd_ptr][0];
    out_byteen = byteen_mem[rd_ptr][WORD_SIZE-1:0];
    out_addr   = addr_mem[rd_ptr][ADDR_WIDTH-1:0];
    out_data   = data_mem[rd_ptr][DW-1:0];
    out_tag    = tag_mem[rd_ptr];
    for (int i = N - 1; i >= 0; i--) begin
      if (head_mask[i]) begin
        out_tid     = TW'(i);
        lane_sel    = '0;
        lane_sel[i] = 1'b1;
        out_rw      = rw_mem[rd_ptr][i];
        out_byteen  = byteen_mem[rd_ptr][i*WORD_SIZE +: WORD_SIZE];
        out_addr    = addr_mem[rd_ptr][i*ADDR_WIDTH +: ADDR_WIDTH];
        out_data    = data_mem[rd_ptr][i*DW +: DW];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      size      <= '0;
      head_mask <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (retire) rd_ptr <= rd_ptr + PW'(1);
      size      <= size_next;
      empty     <= size_next == '0;
      full      <= size_next == SW'(QUEUE_SIZE);
      head_mask <= retire ? next_head : do_pop ? rest : (empty && accept) ? push_valid : head_mask;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      mask_mem[wr_ptr]   <= push_valid;
      rw_mem[wr_ptr]     <= push_rw;
      byteen_mem[wr_ptr] <= push_byteen;
      addr_mem[wr_ptr]   <= push_addr;
      data_mem[wr_ptr]   <= push_data;
      tag_mem[wr_ptr]    <= push_tag;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(|push_valid && full)) else $warning("push dropped: queue full");
      assert (!(pop && !out_valid)) else $warning("pop ignored: no valid lane");
    end
  end
endmodule
